// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the sr_latch sequencer.
package sr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                  req,
  input  logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                  gnt,
  output logic                          valid
);

  logic [N-1:0] rot;
  logic [N-1:0] oh;
  logic         found;

  // Rotate so bit 0 is the pointer position, pick lowest, rotate back.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    oh    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign gnt   = N'(({oh, oh} << ptr) >> N);
  assign valid = |req;

endmodule

// File: rtl/sr_latch_sequencer.sv
// Arbitrates N requesters onto one sr_latch and drives clean, exclusive S/R pulses.
module sr_latch_sequencer
  import sr_seq_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [N_REQ-1:0] in_req,
  input  logic [N_REQ-1:0] in_op,
  input  logic             in_q,
  output logic             out_s,
  output logic             out_r,
  output logic [N_REQ-1:0] out_gnt,
  output logic [N_REQ-1:0] out_ack,
  output logic             out_err,
  output logic             out_busy
);

  localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_q, s_d, r_q, r_d;
  logic             op_q, op_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win, next_ptr;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (in_req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) win = PW'(i);
    end
    next_ptr = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      op_q    <= 1'b0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // S/R are set on the grant edge so the pulse starts in the first DRIVE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    r_d     = r_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    out_ack = '0;
    out_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          op_d    = |(in_op & arb_gnt);
          s_d     = (op_d == OP_SET);
          r_d     = (op_d != OP_SET);
          cnt_d   = CW'(PULSE_CYCLES - 1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        out_ack = gnt_q;
        out_err = (in_q != op_q);
        gnt_d   = '0;
        ptr_d   = next_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_s    = s_q;
  assign out_r    = r_q;
  assign out_gnt  = gnt_q;
  assign out_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer with a behavioural latch model on in_q.
module tb_sr_latch_sequencer;

  localparam int N = 4;
  localparam int P = 2;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] op  = '0;
  logic         in_q;
  logic         out_s, out_r, out_err, out_busy;
  logic [N-1:0] out_gnt, out_ack;

  logic q_lat = 1'b0;
  logic stuck = 1'b0;
  int   vecs = 0, errs = 0, overlap = 0;
  int   n;

  sr_latch_sequencer #(.N_REQ(N), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .in_req   (req),
    .in_op    (op),
    .in_q     (in_q),
    .out_s    (out_s),
    .out_r    (out_r),
    .out_gnt  (out_gnt),
    .out_ack  (out_ack),
    .out_err  (out_err),
    .out_busy (out_busy)
  );

  always #5 clk = ~clk;

  always @(out_s or out_r) begin
    if (out_s)      q_lat = 1'b1;
    else if (out_r) q_lat = 1'b0;
  end
  assign in_q = stuck ? 1'b0 : q_lat;

  always @(posedge clk) if (out_s && out_r) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (out_ack == '0 && cyc < 20);
    check("ack_seen", 32'(out_ack != '0), 32'd1);
  endtask

  initial begin
    tick(); tick();
    check("reset", {out_s, out_r, out_gnt, out_ack, out_err, out_busy}, '0);
    rst = 1'b0;

    // single set from requester 0
    req = 4'b0001; op = 4'b0001;
    tick(); check("set_c1", {out_s, out_r, out_gnt, out_busy}, {1'b1, 1'b0, 4'b0001, 1'b1});
    tick(); check("set_c2", {out_s, out_r}, 2'b10);
    tick(); check("set_settle", {out_s, out_r, out_ack, out_busy}, {2'b00, 4'b0000, 1'b1});
    tick(); check("set_ack", {out_ack, out_err}, {4'b0001, 1'b0});
    req = '0;
    tick(); check("set_done", {out_ack, out_busy, in_q}, {4'b0000, 1'b0, 1'b1});

    // single reset from requester 2
    req = 4'b0100; op = 4'b0000;
    tick(); check("rst_c1", {out_s, out_r, out_gnt}, {1'b0, 1'b1, 4'b0100});
    tick(); check("rst_c2", {out_s, out_r}, 2'b01);
    tick(); check("rst_settle", {out_s, out_r}, 2'b00);
    tick(); check("rst_ack", {out_ack, out_err}, {4'b0100, 1'b0});
    req = '0;
    tick(); check("rst_done", {out_ack, in_q}, {4'b0000, 1'b0});

    // contention from pointer 0
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; op = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      check($sformatf("rr_ack%0d", k), {out_err, out_ack}, {1'b0, 4'(1 << (k % 4))});
      check($sformatf("rr_gap%0d", k), n, (k == 0) ? 4 : 5);
    end
    req = '0;
    tick(); check("rr_ack_pulse", out_ack, 4'b0000);

    // in_q stuck low on a set from requester 2
    stuck = 1'b1; req = 4'b0100; op = 4'b0100;
    wait_ack(n);
    check("err_ack", {out_ack, out_err}, {4'b0100, 1'b1});
    check("err_lat", n, 4);
    req = '0; stuck = 1'b0;
    tick();

    // reset during DRIVE; pointer is 3 beforehand, 0 after
    req = 4'b1001; op = 4'b1001;
    tick(); check("mid_gnt", {out_s, out_gnt}, {1'b1, 4'b1000});
    #2 rst = 1'b1;
    #1 check("mid_async", {out_s, out_r, out_gnt, out_busy, out_ack}, '0);
    tick(); tick();
    check("mid_held", {out_ack, out_busy}, '0);
    rst = 1'b0;
    wait_ack(n);
    check("mid_regrant", out_ack, 4'b0001);
    check("mid_lat", n, 4);
    req = '0;
    tick();

    // requester 1 drops req and flips op during DRIVE
    req = 4'b0010; op = 4'b0000;
    tick(); check("drop_c1", {out_s, out_r, out_gnt}, {1'b0, 1'b1, 4'b0010});
    req = '0; op = 4'b0010;
    tick(); check("drop_c2", {out_s, out_r}, 2'b01);
    tick(); check("drop_settle", {out_s, out_r, out_busy}, 3'b001);
    tick(); check("drop_ack", {out_ack, out_err}, {4'b0010, 1'b0});
    tick(); check("drop_done", {out_ack, out_busy, in_q}, {4'b0000, 1'b0, 1'b0});

    check("s_r_exclusive", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
